hazard_tag_pipe: RTL and testbench

Producer side of the hazard-detection interface. It captures decode-stage register tags and writeback controls, and carries them down the E/M/W pipeline registers. Those registers drive the stage-tagged destination and write-enable signals that the hazard unit compares against. It also converts the hazard unit's stall requests into pipeline stall/flush controls and keeps saturating hazard performance counters.

---
 rtl/hazard_tag_pipe_pkg.sv | 16 +
 rtl/hazard_tag_pipe_tag_stage_reg.sv | 21 ++
 rtl/hazard_tag_pipe.sv | 122 ++++++++++++
 tb/tb_hazard_tag_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_tag_pipe_pkg.sv
// Shared types and constants for the hazard tag pipeline.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic       rfwe;
    logic       mtorf;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rtd;
  } stage_tag_t;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_tag_pipe_tag_stage_reg.sv
// One pipeline register holding a stage tag, with sync reset and flush-to-bubble.
module tag_stage_reg
  import hazard_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  stage_tag_t i_d,
  output stage_tag_t o_q
);

  stage_tag_t r_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) r_tag <= TAG_BUBBLE;
    else                  r_tag <= i_d;
  end

  assign o_q = r_tag;

endmodule

// File: rtl/hazard_tag_pipe.sv
// Carries decode tags down E/M/W, derives stall/flush controls and keeps
// saturating stall counters plus a retired-instruction counter.
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RET_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ValidD,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rdD,
  input  logic             RegDstD,
  input  logic             RFWED,
  input  logic             MtoRFSelD,
  input  logic             LWStall,
  input  logic             BRStall,
  input  logic             PCSrcD,
  input  logic             ClrCnt,
  output logic [4:0]       rsE,
  output logic [4:0]       rtE,
  output logic [4:0]       rtdE,
  output logic [4:0]       rtdM,
  output logic [4:0]       rtdW,
  output logic             RFWEE,
  output logic             RFWEM,
  output logic             RFWEW,
  output logic             MtoRFSelE,
  output logic             MtoRFSelM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             FlushD,
  output logic [CNT_W-1:0] LwStallCnt,
  output logic [CNT_W-1:0] BrStallCnt,
  output logic [RET_W-1:0] RetireCnt
);

  logic       w_stall;
  logic [4:0] w_dst;
  stage_tag_t w_tag_d;
  stage_tag_t w_tag_e;
  stage_tag_t w_tag_m;
  stage_tag_t w_tag_w;

  logic [CNT_W-1:0] r_lw_cnt;
  logic [CNT_W-1:0] r_br_cnt;
  logic [RET_W-1:0] r_ret_cnt;

  // A stall outranks a taken branch: its compare operands are not ready yet.
  always_comb begin
    w_stall = LWStall | BRStall;
    StallF  = w_stall;
    StallD  = w_stall;
    FlushE  = w_stall;
    FlushD  = PCSrcD & ~w_stall;
  end

  always_comb begin
    w_dst         = RegDstD ? rdD : rtD;
    w_tag_d       = TAG_BUBBLE;
    w_tag_d.valid = 1'b1;
    w_tag_d.rfwe  = RFWED && (w_dst != REG_ZERO);
    w_tag_d.mtorf = MtoRFSelD;
    w_tag_d.rs    = rsD;
    w_tag_d.rt    = rtD;
    w_tag_d.rtd   = w_dst;
  end

  tag_stage_reg u_stage_e (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (w_stall | ~ValidD),
    .i_d     (w_tag_d),
    .o_q     (w_tag_e)
  );

  tag_stage_reg u_stage_m (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (1'b0),
    .i_d     (w_tag_e),
    .o_q     (w_tag_m)
  );

  tag_stage_reg u_stage_w (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (1'b0),
    .i_d     (w_tag_m),
    .o_q     (w_tag_w)
  );

  always_ff @(posedge CLK) begin
    if (RST || ClrCnt) begin
      r_lw_cnt  <= '0;
      r_br_cnt  <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (LWStall && (r_lw_cnt != '1)) r_lw_cnt <= r_lw_cnt + CNT_W'(1);
      if (BRStall && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_tag_w.valid)               r_ret_cnt <= r_ret_cnt + RET_W'(1);
    end
  end

  assign rsE        = w_tag_e.rs;
  assign rtE        = w_tag_e.rt;
  assign rtdE       = w_tag_e.rtd;
  assign rtdM       = w_tag_m.rtd;
  assign rtdW       = w_tag_w.rtd;
  assign RFWEE      = w_tag_e.rfwe;
  assign RFWEM      = w_tag_m.rfwe;
  assign RFWEW      = w_tag_w.rfwe;
  assign MtoRFSelE  = w_tag_e.mtorf;
  assign MtoRFSelM  = w_tag_m.mtorf;
  assign LwStallCnt = r_lw_cnt;
  assign BrStallCnt = r_br_cnt;
  assign RetireCnt  = r_ret_cnt;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: control truth table plus pipeline sequences.
module tb_hazard_tag_pipe;

  logic        CLK = 1'b0;
  logic        RST, ValidD, RegDstD, RFWED, MtoRFSelD;
  logic        LWStall, BRStall, PCSrcD, ClrCnt;
  logic [4:0]  rsD, rtD, rdD;
  logic [4:0]  rsE, rtE, rtdE, rtdM, rtdW;
  logic        RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM;
  logic        StallF, StallD, FlushE, FlushD;
  logic [15:0] LwStallCnt, BrStallCnt;
  logic [31:0] RetireCnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  hazard_tag_pipe #(.CNT_W(16), .RET_W(32)) dut (
    .CLK(CLK), .RST(RST), .ValidD(ValidD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .RegDstD(RegDstD),
    .RFWED(RFWED), .MtoRFSelD(MtoRFSelD),
    .LWStall(LWStall), .BRStall(BRStall), .PCSrcD(PCSrcD), .ClrCnt(ClrCnt),
    .rsE(rsE), .rtE(rtE), .rtdE(rtdE), .rtdM(rtdM), .rtdW(rtdW),
    .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt), .RetireCnt(RetireCnt)
  );

  typedef struct {
    logic rst;
    logic lw;
    logic br;
    logic pc;
    logic exp_stall;
    logic exp_flushd;
  } ctl_vec_t;

  ctl_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_d();
    ValidD = 1'b0; RFWED = 1'b0; MtoRFSelD = 1'b0; RegDstD = 1'b0;
    rsD = '0; rtD = '0; rdD = '0;
  endtask

  initial begin
    RST = 1'b1; ClrCnt = 1'b0; LWStall = 1'b0; BRStall = 1'b0; PCSrcD = 1'b0;
    idle_d();

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      RST = vecs[i].rst; LWStall = vecs[i].lw; BRStall = vecs[i].br; PCSrcD = vecs[i].pc;
      #1;
      chk($sformatf("v%0d StallF", i), 32'(StallF), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d StallD", i), 32'(StallD), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d FlushE", i), 32'(FlushE), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d FlushD", i), 32'(FlushD), 32'(vecs[i].exp_flushd));
    end

    // Reset state
    RST = 1'b1; LWStall = 1'b0; BRStall = 1'b0; PCSrcD = 1'b0;
    step(); step();
    RST = 1'b0;
    chk("rst rtdE", 32'(rtdE), 0);
    chk("rst rtdW", 32'(rtdW), 0);
    chk("rst RFWEE", 32'(RFWEE), 0);
    chk("rst LwCnt", 32'(LwStallCnt), 0);
    chk("rst BrCnt", 32'(BrStallCnt), 0);
    chk("rst Ret", RetireCnt, 0);

    // lw $8 through the pipe
    ValidD = 1'b1; RFWED = 1'b1; MtoRFSelD = 1'b1; RegDstD = 1'b0;
    rsD = 5'd3; rtD = 5'd8; rdD = 5'd12;
    step();
    idle_d();
    chk("lw MtoRFSelE", 32'(MtoRFSelE), 1);
    chk("lw rtdE", 32'(rtdE), 8);
    chk("lw rsE", 32'(rsE), 3);
    chk("lw rtE", 32'(rtE), 8);
    chk("lw RFWEE", 32'(RFWEE), 1);
    step();
    chk("lw rtdM", 32'(rtdM), 8);
    chk("lw MtoRFSelM", 32'(MtoRFSelM), 1);
    chk("lw rtdE bubble", 32'(rtdE), 0);
    step();
    chk("lw rtdW", 32'(rtdW), 8);
    chk("lw RFWEW", 32'(RFWEW), 1);
    chk("lw Ret pre", RetireCnt, 0);
    step();
    chk("lw Ret", RetireCnt, 1);

    // Two-cycle load stall with a valid instruction held in D
    ValidD = 1'b1; RFWED = 1'b1; RegDstD = 1'b1; rdD = 5'd9; rtD = 5'd4;
    LWStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lws StallF", 32'(StallF), 1);
      chk("lws FlushE", 32'(FlushE), 1);
      step();
      chk("lws RFWEE", 32'(RFWEE), 0);
      chk("lws rtdE", 32'(rtdE), 0);
    end
    LWStall = 1'b0;
    idle_d();
    step();
    chk("lws rtdW b1", 32'(rtdW), 0);
    chk("lws RFWEW b1", 32'(RFWEW), 0);
    step();
    chk("lws rtdW b2", 32'(rtdW), 0);
    step(); step();
    chk("lws LwCnt", 32'(LwStallCnt), 2);
    chk("lws Ret", RetireCnt, 1);

    // Write to $0 never reports a write
    ValidD = 1'b1; RFWED = 1'b1; RegDstD = 1'b1; rdD = 5'd0; rtD = 5'd7;
    step();
    idle_d();
    chk("r0 RFWEE", 32'(RFWEE), 0);
    step();
    chk("r0 RFWEM", 32'(RFWEM), 0);
    step();
    chk("r0 RFWEW", 32'(RFWEW), 0);
    step();
    chk("r0 Ret", RetireCnt, 2);

    // Both stall requests in one cycle, then ClrCnt discarding events
    LWStall = 1'b1; BRStall = 1'b1;
    step();
    chk("both Lw", 32'(LwStallCnt), 3);
    chk("both Br", 32'(BrStallCnt), 1);
    ClrCnt = 1'b1;
    step();
    ClrCnt = 1'b0; LWStall = 1'b0; BRStall = 1'b0;
    chk("clr Lw", 32'(LwStallCnt), 0);
    chk("clr Br", 32'(BrStallCnt), 0);
    chk("clr Ret", RetireCnt, 0);

    // Branch-stall counter saturation
    BRStall = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat FFFE", 32'(BrStallCnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("sat FFFF", 32'(BrStallCnt), 32'hFFFF);
    ClrCnt = 1'b1;
    step();
    ClrCnt = 1'b0; BRStall = 1'b0;
    chk("sat clr", 32'(BrStallCnt), 0);

    // Mid-stream reset drops in-flight instructions
    for (int i = 0; i < 3; i++) begin
      ValidD = 1'b1; RFWED = 1'b1; RegDstD = 1'b0; rtD = 5'(5 + i);
      step();
    end
    idle_d();
    chk("mr rtdW pre", 32'(rtdW), 5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mr RFWEE", 32'(RFWEE), 0);
    chk("mr RFWEM", 32'(RFWEM), 0);
    chk("mr RFWEW", 32'(RFWEW), 0);
    chk("mr rtdW", 32'(rtdW), 0);
    chk("mr Ret", RetireCnt, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr stale rtdW", 32'(rtdW), 0);
    end
    chk("mr Ret post", RetireCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
